// File: rtl/wiper_pkg.sv
// Shared types, demand codes and phase-length helper for the wiper motor sequencer.
package wiper_pkg;

    typedef enum logic [1:0] {
        PARK = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } wiper_state_t;

    typedef enum logic [1:0] {
        SPD_OFF  = 2'd0,
        SPD_LOW  = 2'd1,
        SPD_HIGH = 2'd3
    } wiper_spd_t;

    // Demand codes as they arrive from the rain FSM and the manual switch.
    localparam logic [1:0] REQ_OFF     = 2'd0;
    localparam logic [1:0] REQ_LOW     = 2'd1;
    localparam logic [1:0] REQ_ILLEGAL = 2'd2;
    localparam logic [1:0] REQ_HIGH    = 2'd3;

    localparam int unsigned T_LOW_DEF  = 4;
    localparam int unsigned T_HIGH_DEF = 2;

    // The illegal code is run as low speed so the glass is still wiped.
    function automatic wiper_spd_t req_to_spd(input logic [1:0] code);
        case (code)
            REQ_OFF:  return SPD_OFF;
            REQ_HIGH: return SPD_HIGH;
            default:  return SPD_LOW;
        endcase
    endfunction

    // Cycles per half-sweep for a latched speed.
    function automatic int unsigned t_of(input wiper_spd_t spd,
                                         input int unsigned t_low  = T_LOW_DEF,
                                         input int unsigned t_high = T_HIGH_DEF);
        return (spd == SPD_HIGH) ? t_high : t_low;
    endfunction

endpackage

// File: rtl/wiper_phase_timer.sv
// Half-sweep down-counter: loaded with T-1 on phase entry, expired at zero.
module wiper_phase_timer #(
    parameter int unsigned NBITS_CNT = 4
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 load,
    input  logic [NBITS_CNT-1:0] load_val,
    output logic                 expired
);

    localparam logic [NBITS_CNT-1:0] CNT_ONE = {{(NBITS_CNT-1){1'b0}}, 1'b1};

    logic [NBITS_CNT-1:0] count_q;
    logic [NBITS_CNT-1:0] count_d;

    // Next count: reload wins, otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal-count compare.
    always_comb begin
        expired = (count_q == '0);
    end

endmodule

// File: rtl/wiper_motor_sequencer.sv
// Wiper motor sequencer: arbitrates auto/manual demand and runs full UP/DOWN
// sweeps, changing speed or stopping only at park.
// Optional feature macro: WIPER_WASH_EN (adds wash_pulse input and a
// three-sweep wash cycle).
//
// state | meaning
// PARK  | motor off at park position, waiting for a non-off demand
// UP    | first half-sweep, T(spd) cycles
// DOWN  | second half-sweep, T(spd) cycles; last cycle counts the sweep
module wiper_motor_sequencer
    import wiper_pkg::*;
#(
    parameter int unsigned T_LOW     = 4,
    parameter int unsigned T_HIGH    = 2,
    parameter int unsigned NBITS_CNT = 4
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic [1:0] auto_req,
    input  logic [1:0] man_req,
    input  logic       man_en,
`ifdef WIPER_WASH_EN
    input  logic       wash_pulse,
`endif
    output logic       motor_on,
    output logic       motor_fast,
    output logic [1:0] phase,
    output logic [7:0] sweep_cnt,
    output logic       err
);

    wiper_state_t         state_q, state_d;
    wiper_spd_t           spd_q, spd_d;
    logic [7:0]           sweep_cnt_q, sweep_cnt_d;
    logic                 err_q, err_d;

    logic [1:0]           req_sel;
    wiper_spd_t           req_spd;
    logic                 sweep_done;
    logic                 timer_load;
    logic [NBITS_CNT-1:0] timer_load_val;
    logic                 timer_expired;

    wiper_phase_timer #(
        .NBITS_CNT (NBITS_CNT)
    ) u_phase_timer (
        .clk_2    (clk_2),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .expired  (timer_expired)
    );

    // The DOWN terminal cycle is the only park/re-latch decision point mid-run.
    always_comb begin
        sweep_done = (state_q == DOWN) && timer_expired;
    end

`ifdef WIPER_WASH_EN
    logic [1:0] wash_left_q, wash_left_d;

    // Wash counter: a pulse reloads to 3 (even alongside a completion),
    // otherwise each completed sweep consumes one.
    always_comb begin
        wash_left_d = wash_left_q;
        if (wash_pulse) begin
            wash_left_d = 2'd3;
        end else if (sweep_done && (wash_left_q != 2'd0)) begin
            wash_left_d = wash_left_q - 2'd1;
        end
    end

    // Wash counter register.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            wash_left_q <= 2'd0;
        end else begin
            wash_left_q <= wash_left_d;
        end
    end
`endif

    // Demand arbitration; with wash active the post-update wash count decides,
    // so the completion of the last wash sweep can already park.
    always_comb begin
        req_sel = man_en ? man_req : auto_req;
        req_spd = req_to_spd(req_sel);
`ifdef WIPER_WASH_EN
        if ((wash_left_d != 2'd0) && (req_spd == SPD_OFF)) begin
            req_spd = SPD_LOW;
        end
`endif
    end

    // State, speed, sweep counter and sticky error registers.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q     <= PARK;
            spd_q       <= SPD_OFF;
            sweep_cnt_q <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            spd_q       <= spd_d;
            sweep_cnt_q <= sweep_cnt_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic; demand is only looked at in PARK and at sweep end.
    always_comb begin
        state_d     = state_q;
        spd_d       = spd_q;
        sweep_cnt_d = sweep_cnt_q;
        err_d       = err_q | (req_sel == REQ_ILLEGAL);
        timer_load  = 1'b0;
        case (state_q)
            PARK: begin
                if (req_spd != SPD_OFF) begin
                    state_d    = UP;
                    spd_d      = req_spd;
                    timer_load = 1'b1;
                end
            end
            UP: begin
                if (timer_expired) begin
                    state_d    = DOWN;
                    timer_load = 1'b1;
                end
            end
            DOWN: begin
                if (sweep_done) begin
                    sweep_cnt_d = sweep_cnt_q + 8'd1;
                    if (req_spd == SPD_OFF) begin
                        state_d = PARK;
                        spd_d   = SPD_OFF;
                    end else begin
                        state_d    = UP;
                        spd_d      = req_spd;
                        timer_load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = PARK;
                spd_d   = SPD_OFF;
            end
        endcase
        timer_load_val = NBITS_CNT'(t_of(spd_d, T_LOW, T_HIGH) - 1);
    end

    // Outputs decoded straight from registered state and speed.
    always_comb begin
        motor_on   = (state_q != PARK);
        motor_fast = (state_q != PARK) && (spd_q == SPD_HIGH);
        phase      = state_q;
        sweep_cnt  = sweep_cnt_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_wiper_motor_sequencer.sv
// Directed bench for wiper_motor_sequencer (default T_LOW=4, T_HIGH=2).
// Inputs change and outputs are sampled on the falling edge of clk_2.
module tb_wiper_motor_sequencer;

    logic       clk_2;
    logic       reset;
    logic [1:0] auto_req;
    logic [1:0] man_req;
    logic       man_en;
`ifdef WIPER_WASH_EN
    logic       wash_pulse;
`endif
    logic       motor_on;
    logic       motor_fast;
    logic [1:0] phase;
    logic [7:0] sweep_cnt;
    logic       err;

    int errors = 0;
    int checks = 0;

    wiper_motor_sequencer dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .auto_req   (auto_req),
        .man_req    (man_req),
        .man_en     (man_en),
`ifdef WIPER_WASH_EN
        .wash_pulse (wash_pulse),
`endif
        .motor_on   (motor_on),
        .motor_fast (motor_fast),
        .phase      (phase),
        .sweep_cnt  (sweep_cnt),
        .err        (err)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic tick();
        @(negedge clk_2);
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        int exp_ph;
        reset    = 1'b1;
        auto_req = 2'd0;
        man_req  = 2'd0;
        man_en   = 1'b0;
`ifdef WIPER_WASH_EN
        wash_pulse = 1'b0;
`endif

        // T1: reset for two cycles, then idle
        tick();
        chk("rst_phase", phase, 0);
        chk("rst_on", motor_on, 0);
        tick();
        chk("rst_cnt", sweep_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_fast", motor_fast, 0);
        reset = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("t1_phase", phase, 0);
            chk("t1_on", motor_on, 0);
            chk("t1_cnt", sweep_cnt, 0);
        end

        // T2: auto low; demand dropped during the second sweep
        auto_req = 2'd1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c <= 4 || (c >= 9 && c <= 12)) exp_ph = 1;
            else if (c <= 16)                  exp_ph = 2;
            else                               exp_ph = 0;
            chk("t2_phase", phase, exp_ph);
            chk("t2_fast", motor_fast, 0);
            if (c == 8)  chk("t2_cnt_c8", sweep_cnt, 0);
            if (c == 9) begin
                chk("t2_cnt_c9", sweep_cnt, 1);
                auto_req = 2'd0;
            end
            if (c == 17) chk("t2_cnt_park", sweep_cnt, 2);
        end

        // T3: manual off overrides auto high, then auto high takes over
        man_en   = 1'b1;
        man_req  = 2'd0;
        auto_req = 2'd3;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("t3_hold_park", phase, 0);
        end
        man_en = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 9)                       exp_ph = 0;
            else if (((c - 1) % 4) < 2)       exp_ph = 1;
            else                              exp_ph = 2;
            chk("t3_phase", phase, exp_ph);
            chk("t3_fast", motor_fast, (c <= 8) ? 1 : 0);
            if (c == 5) auto_req = 2'd0;
            if (c == 9) chk("t3_cnt", sweep_cnt, 4);
        end

        // T4: speed change mid-sweep takes effect only at the next sweep
        auto_req = 2'd1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c <= 4)       exp_ph = 1;
            else if (c <= 8)  exp_ph = 2;
            else if (c <= 10) exp_ph = 1;
            else if (c <= 12) exp_ph = 2;
            else              exp_ph = 0;
            chk("t4_phase", phase, exp_ph);
            chk("t4_fast", motor_fast, (c >= 9 && c <= 12) ? 1 : 0);
            if (c == 2)  auto_req = 2'd3;
            if (c == 10) auto_req = 2'd0;
            if (c == 13) chk("t4_cnt", sweep_cnt, 6);
        end

        // Illegal code on the unselected input is ignored
        man_en   = 1'b1;
        man_req  = 2'd0;
        auto_req = 2'd2;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("unsel_err", err, 0);
            chk("unsel_phase", phase, 0);
        end

        // T5: illegal auto code -> sticky err, low timing, reset mid-DOWN
        man_en = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c <= 6) begin
                chk("t5_err", err, 1);
                chk("t5_phase", phase, (c <= 4) ? 1 : 2);
                chk("t5_fast", motor_fast, 0);
            end
            if (c == 1) auto_req = 2'd0;
            if (c == 6) reset = 1'b1;
            if (c == 7) begin
                chk("t5_rst_phase", phase, 0);
                chk("t5_rst_on", motor_on, 0);
                chk("t5_rst_err", err, 0);
                chk("t5_rst_cnt", sweep_cnt, 0);
                reset = 1'b0;
            end
        end

        // sweep_cnt wrap: 255 high sweeps, then one more wraps to 0
        auto_req = 2'd3;
        for (int c = 1; c <= 1025; c++) begin
            tick();
            if (c == 1020) chk("wrap_cnt_254", sweep_cnt, 254);
            if (c == 1021) begin
                chk("wrap_cnt_255", sweep_cnt, 255);
                chk("wrap_phase_up", phase, 1);
                auto_req = 2'd0;
            end
            if (c == 1024) begin
                chk("wrap_cnt_hold", sweep_cnt, 255);
                chk("wrap_phase_dn", phase, 2);
            end
            if (c == 1025) begin
                chk("wrap_cnt_0", sweep_cnt, 0);
                chk("wrap_phase_park", phase, 0);
            end
        end

`ifdef WIPER_WASH_EN
        // T6: wash pulse with no demand -> exactly three low sweeps
        for (int c = 1; c <= 31; c++) begin
            tick();
            if (c <= 3 || c >= 28)        exp_ph = 0;
            else if (((c - 4) % 8) < 4)   exp_ph = 1;
            else                          exp_ph = 2;
            chk("t6_phase", phase, exp_ph);
            chk("t6_fast", motor_fast, 0);
            if (c == 3) wash_pulse = 1'b1;
            if (c == 4) wash_pulse = 1'b0;
            if (c == 27) chk("t6_cnt_27", sweep_cnt, 2);
            if (c == 28) chk("t6_cnt_28", sweep_cnt, 3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
